// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver: synchronises and filters the PS/2 lines, checks start/odd-parity/stop,
// strobes each good scancode and keeps a four-byte history for the seven-segment display driver.
module ps2_kbd_rx #(
   parameter int unsigned FILT_LEN       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic        clk_100mhz,
   input  logic        nrst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [7:0]  code,
   output logic        code_valid,
   output logic        err,
   output logic [31:0] history
);

   localparam int unsigned FW = $clog2(FILT_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_meta, sync_clk, data_meta, sync_data;
   logic          filt_clk, filt_prev;
   logic [FW-1:0] filt_cnt;
   logic          fe;

   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_ok, par_ok_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;
   logic [7:0]    code_n;
   logic          code_valid_n, err_n;
   logic [31:0]   history_n;

   // Two-flop synchronisers and the glitch filter on the PS/2 clock
   always_ff @(posedge clk_100mhz or negedge nrst) begin
      if (!nrst) begin
         clk_meta  <= 1'b0;
         sync_clk  <= 1'b0;
         data_meta <= 1'b0;
         sync_data <= 1'b0;
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         clk_meta  <= ps2_clk;
         sync_clk  <= clk_meta;
         data_meta <= ps2_data;
         sync_data <= data_meta;
         filt_prev <= filt_clk;
         if (sync_clk != filt_clk) begin
            if (filt_cnt == FW'(FILT_LEN - 1)) begin
               filt_clk <= sync_clk;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign fe = filt_prev & ~filt_clk;

   // Frame state and registered outputs
   always_ff @(posedge clk_100mhz or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_ok     <= 1'b0;
         tmo_cnt    <= '0;
         code       <= '0;
         code_valid <= 1'b0;
         err        <= 1'b0;
         history    <= '0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         par_ok     <= par_ok_n;
         tmo_cnt    <= tmo_cnt_n;
         code       <= code_n;
         code_valid <= code_valid_n;
         err        <= err_n;
         history    <= history_n;
      end
   end

   // Next-state: frame decode on filtered falling edges, plus the stalled-frame timeout
   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shreg_n      = shreg;
      par_ok_n     = par_ok;
      code_n       = code;
      code_valid_n = 1'b0;
      err_n        = 1'b0;
      history_n    = history;
      tmo_cnt_n    = (state == IDLE || fe) ? '0 : tmo_cnt + TW'(1);

      case (state)
         IDLE: begin
            if (fe && !sync_data) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            if (fe) begin
               shreg_n   = {sync_data, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
         end
         PARITY: begin
            if (fe) begin
               par_ok_n = (^shreg) ^ sync_data;
               state_n  = STOP;
            end
         end
         STOP: begin
            if (fe) begin
               state_n = IDLE;
               if (sync_data && par_ok) begin
                  code_n       = shreg;
                  code_valid_n = 1'b1;
                  history_n    = {history[23:0], shreg};
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // An edge in the same cycle keeps the frame alive
      if (state != IDLE && !fe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n   = IDLE;
         err_n     = 1'b1;
         tmo_cnt_n = '0;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Randomised bench for ps2_kbd_rx: drives PS/2 frames and checks code, history and strobes
// against a byte-level model of what a keyboard frame should produce.
module tb_ps2_kbd_rx;

   localparam int unsigned FILT_LEN       = 8;
   localparam int unsigned TIMEOUT_CYCLES = 20000;
   localparam int unsigned HALF           = 20;

   logic        clk_100mhz = 1'b0;
   logic        nrst       = 1'b0;
   logic        ps2_clk    = 1'b1;
   logic        ps2_data   = 1'b1;
   logic [7:0]  code;
   logic        code_valid;
   logic        err;
   logic [31:0] history;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cv_cnt = 0;
   int          err_cnt = 0;
   logic        prev_cv = 1'b0;
   logic        prev_err = 1'b0;
   logic [7:0]  m_code;
   logic [31:0] m_hist;
   int          e0, c0;
   logic [7:0]  rb;
   int unsigned kind;

   ps2_kbd_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk_100mhz (clk_100mhz),
      .nrst       (nrst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_valid (code_valid),
      .err        (err),
      .history    (history)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk_100mhz);
   endtask

   // Device changes data while the clock is high, host samples on the falling edge
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bad);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ par_flip);
      ps2_bit(~stop_bad);
      ps2_data = 1'b1;
   endtask

   task automatic frame_check(input logic [7:0] b, input logic par_flip, input logic stop_bad);
      int   cv_base;
      int   err_base;
      logic good;
      cv_base  = cv_cnt;
      err_base = err_cnt;
      good     = !par_flip && !stop_bad;
      send_frame(b, par_flip, stop_bad);
      wait_clk(4);
      if (good) begin
         m_code = b;
         m_hist = {m_hist[23:0], b};
      end
      chk("code", 32'(code), 32'(m_code));
      chk("history", history, m_hist);
      chk("code_valid_pulses", 32'(cv_cnt - cv_base), 32'(good));
      chk("err_pulses", 32'(err_cnt - err_base), 32'(!good));
   endtask

   // Strobe monitor: counts pulses, checks exclusivity and single-cycle width
   always @(negedge clk_100mhz) begin
      if (nrst) begin
         if (code_valid) cv_cnt++;
         if (err) err_cnt++;
         if (code_valid || err) chk("cv_err_exclusive", 32'(code_valid & err), 32'd0);
         if (code_valid) chk("code_valid_width", 32'(prev_cv), 32'd0);
         if (err) chk("err_width", 32'(prev_err), 32'd0);
      end
      prev_cv  = code_valid;
      prev_err = err;
   end

   initial begin
      m_code = '0;
      m_hist = '0;
      wait_clk(5);
      @(negedge clk_100mhz);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_code_valid", 32'(code_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_history", history, 32'd0);
      nrst = 1'b1;
      wait_clk(10);

      // Single good frame, then the history sequence
      frame_check(8'h1C, 1'b0, 1'b0);
      chk("hist_first", history, 32'h0000001C);
      frame_check(8'hF0, 1'b0, 1'b0);
      frame_check(8'h1C, 1'b0, 1'b0);
      frame_check(8'h32, 1'b0, 1'b0);
      chk("hist_four", history, 32'h1CF01C32);
      frame_check(8'h29, 1'b0, 1'b0);
      chk("hist_five", history, 32'hF01C3229);

      // Bad parity, bad stop
      frame_check(8'h1C, 1'b1, 1'b0);
      frame_check(8'h1C, 1'b0, 1'b1);

      // Short clock glitch with data low must not start a frame
      ps2_data = 1'b0;
      wait_clk(30);
      ps2_clk = 1'b0;
      wait_clk(FILT_LEN - 2);
      ps2_clk = 1'b1;
      wait_clk(30);
      ps2_data = 1'b1;
      frame_check(8'h12, 1'b0, 1'b0);

      // Idle-line falling edge with data high is ignored silently
      e0 = err_cnt;
      ps2_bit(1'b1);
      wait_clk(10);
      chk("idle_fe_no_err", 32'(err_cnt - e0), 32'd0);
      frame_check(8'h45, 1'b0, 1'b0);

      // Stalled frame after four data bits times out
      e0 = err_cnt;
      c0 = cv_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
      ps2_data = 1'b1;
      wait_clk(TIMEOUT_CYCLES + 50);
      chk("timeout_err", 32'(err_cnt - e0), 32'd1);
      chk("timeout_no_cv", 32'(cv_cnt - c0), 32'd0);
      chk("timeout_code", 32'(code), 32'(m_code));
      frame_check(8'h5A, 1'b0, 1'b0);
      chk("after_timeout_code", 32'(code), 32'h5A);

      // Reset mid-frame discards everything without an error strobe
      e0 = err_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'($urandom));
      wait_clk(5);
      nrst = 1'b0;
      wait_clk(3);
      @(negedge clk_100mhz);
      chk("midrst_code", 32'(code), 32'd0);
      chk("midrst_history", history, 32'd0);
      chk("midrst_strobes", 32'({code_valid, err}), 32'd0);
      ps2_data = 1'b1;
      m_code = '0;
      m_hist = '0;
      wait_clk(3);
      nrst = 1'b1;
      wait_clk(20);
      chk("midrst_no_err", 32'(err_cnt - e0), 32'd0);
      frame_check(8'h1C, 1'b0, 1'b0);

      // Random frames, some corrupted, with short or zero gaps
      for (int n = 0; n < 24; n++) begin
         rb   = 8'($urandom);
         kind = $urandom_range(0, 3);
         wait_clk($urandom_range(0, 30));
         frame_check(rb, kind == 2, kind == 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
